// File: rtl/fp_addsub_core.sv
// Multi-cycle single-precision add/sub core: align -> add -> normalize -> round,
// with one-cycle bypass for invalid and infinity operands.
module fp_addsub_core #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             operation_select,
  input  logic             invalid_operation,
  input  logic             perform_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned SigW  = MANT_BITS + 1;  // significand with hidden bit
  localparam int unsigned WorkW = SigW + 3;       // plus guard, round, sticky
  localparam int unsigned ExpW  = EXP_BITS + 2;   // headroom for carry and round

  localparam logic [EXP_BITS-1:0] ExpOnes = '1;
  localparam logic [ExpW-1:0]     ExpInf  = {2'b00, ExpOnes};
  localparam logic [ExpW-1:0]     ExpOne  = ExpW'(1);
  localparam logic [ExpW-1:0]     ExpTwo  = ExpW'(2);
  localparam logic [WIDTH-1:0]    QNaN    = {1'b0, ExpOnes, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WorkW-1:0] mant_a_q, mant_a_d;
  logic [WorkW-1:0] mant_b_q, mant_b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [ExpW-1:0]  exp_q, exp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Align: order operands by magnitude and shift the smaller one right.
  logic [WIDTH-1:0]    big_op, small_op;
  logic [EXP_BITS-1:0] exp_big, exp_small, exp_diff;
  logic [SigW-1:0]     sig_big, sig_small;
  logic [WorkW-1:0]    ext_small, shr_small, lost_mask, align_big;

  always_comb begin
    big_op    = a_q;
    small_op  = b_q;
    if (a_q[WIDTH-2:0] < b_q[WIDTH-2:0]) begin
      big_op   = b_q;
      small_op = a_q;
    end
    exp_big   = big_op[WIDTH-2 -: EXP_BITS];
    exp_small = small_op[WIDTH-2 -: EXP_BITS];
    // Zero exponent covers both zero and denormal: both enter as signed zero.
    sig_big   = (exp_big != '0) ? {1'b1, big_op[MANT_BITS-1:0]} : '0;
    sig_small = (exp_small != '0) ? {1'b1, small_op[MANT_BITS-1:0]} : '0;
    align_big = {sig_big, 3'b000};
    ext_small = {sig_small, 3'b000};
    exp_diff  = exp_big - exp_small;
    lost_mask = '0;
    if (32'(exp_diff) >= WorkW) begin
      shr_small = {{(WorkW-1){1'b0}}, |ext_small};
    end else begin
      lost_mask    = ~({WorkW{1'b1}} << exp_diff);
      shr_small    = ext_small >> exp_diff;
      shr_small[0] = shr_small[0] | (|(ext_small & lost_mask));
    end
  end

  // Add: |A| >= |B| so the difference never goes negative.
  logic [WorkW:0]   sum;
  logic [WorkW-1:0] sum_carry, sum_shl, norm_shl;

  always_comb begin
    if (sign_a_q == sign_b_q) begin
      sum = {1'b0, mant_a_q} + {1'b0, mant_b_q};
    end else begin
      sum = {1'b0, mant_a_q} - {1'b0, mant_b_q};
    end
    sum_carry = {sum[WorkW:2], sum[1] | sum[0]};
    sum_shl   = {sum[WorkW-2:0], 1'b0};
    norm_shl  = {mant_a_q[WorkW-2:0], 1'b0};
  end

  // Round to nearest even on G/R/S; a significand carry bumps the exponent.
  logic                 rnd_up;
  logic [SigW:0]        sig_rnd;
  logic [ExpW-1:0]      exp_rnd;
  logic [MANT_BITS-1:0] frac_rnd;

  always_comb begin
    rnd_up   = mant_a_q[2] & (mant_a_q[1] | mant_a_q[0] | mant_a_q[3]);
    sig_rnd  = {1'b0, mant_a_q[WorkW-1:3]} + {{SigW{1'b0}}, rnd_up};
    exp_rnd  = exp_q + {{(ExpW-1){1'b0}}, sig_rnd[SigW]};
    frac_rnd = sig_rnd[SigW] ? '0 : sig_rnd[MANT_BITS-1:0];
  end

  logic a_in_inf, b_in_inf, sign_b_in;

  always_comb begin
    a_in_inf  = in_a[WIDTH-2 -: EXP_BITS] == ExpOnes;
    b_in_inf  = in_b[WIDTH-2 -: EXP_BITS] == ExpOnes;
    sign_b_in = in_b[WIDTH-1] ^ ~operation_select;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    exp_d    = exp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = {sign_b_in, in_b[WIDTH-2:0]};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = StDone;
          if (invalid_operation) begin
            result_d = QNaN;
          end else if (a_in_inf) begin
            result_d = {in_a[WIDTH-1], ExpOnes, {MANT_BITS{1'b0}}};
          end else if (b_in_inf) begin
            result_d = {sign_b_in, ExpOnes, {MANT_BITS{1'b0}}};
          end else begin
            state_d = StAlign;
          end
        end
      end
      StAlign: begin
        mant_a_d = align_big;
        mant_b_d = shr_small;
        exp_d    = {2'b00, exp_big};
        sign_a_d = big_op[WIDTH-1];
        sign_b_d = small_op[WIDTH-1];
        state_d  = StAdd;
      end
      StAdd: begin
        if (sum == '0) begin
          result_d = {sign_a_q & sign_b_q, {(WIDTH-1){1'b0}}};
          state_d  = StDone;
        end else if (sum[WorkW]) begin
          mant_a_d = sum_carry;
          exp_d    = exp_q + ExpOne;
          state_d  = StRound;
        end else if (sum[WorkW-1]) begin
          mant_a_d = sum[WorkW-1:0];
          state_d  = StRound;
        end else if (exp_q == ExpOne) begin
          result_d = {sign_a_q, {(WIDTH-1){1'b0}}};
          unf_d    = 1'b1;
          state_d  = StDone;
        end else begin
          // First left shift is folded in here; NORM handles the rest.
          mant_a_d = sum_shl;
          exp_d    = exp_q - ExpOne;
          if (sum_shl[WorkW-1]) begin
            state_d = StRound;
          end else if (exp_q == ExpTwo) begin
            result_d = {sign_a_q, {(WIDTH-1){1'b0}}};
            unf_d    = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        mant_a_d = norm_shl;
        exp_d    = exp_q - ExpOne;
        if (norm_shl[WorkW-1]) begin
          state_d = StRound;
        end else if (exp_q == ExpTwo) begin
          result_d = {sign_a_q, {(WIDTH-1){1'b0}}};
          unf_d    = 1'b1;
          state_d  = StDone;
        end
      end
      StRound: begin
        if (exp_rnd >= ExpInf) begin
          result_d = {sign_a_q, ExpOnes, {MANT_BITS{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_a_q, exp_rnd[EXP_BITS-1:0], frac_rnd};
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Denormals are already caught by the zero-exponent test; the hidden bit
  // of the rounded significand is implied by the exponent.
  logic unused_bits;
  assign unused_bits = ^{perform_operation, sig_rnd[MANT_BITS]};

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_addsub_core.sv
// Directed bench for fp_addsub_core: results, flags, latency, backpressure and
// mid-operation reset, all against hand-computed constants.
module tb_fp_addsub_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        operation_select;
  logic        invalid_operation;
  logic        perform_operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_addsub_core dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .operation_select  (operation_select),
    .invalid_operation (invalid_operation),
    .perform_operation (perform_operation),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .result            (result),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "/in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic inv);
    logic [7:0] ea, eb;
    ea                = a[30:23];
    eb                = b[30:23];
    in_a              = a;
    in_b              = b;
    operation_select  = op;
    invalid_operation = inv;
    perform_operation = !inv && (ea != 8'd0) && (eb != 8'd0);
    in_valid          = 1'b1;
  endtask

  // Latency k means out_valid is seen at the k-th falling edge after the accept edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic inv, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_unf, input int exp_lat,
                        input int hold);
    int lat;
    logic stable;
    wait_ready(tag);
    drive(a, b, op, inv);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/result"}, result, exp_res);
    check_eq({tag, "/flags"}, {30'b0, overflow, underflow}, {30'b0, exp_ovf, exp_unf});
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (result !== exp_res || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      check_eq({tag, "/held"}, {31'b0, stable}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "/valid_drop"}, {31'b0, out_valid}, 32'd0);
    check_eq({tag, "/ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    rst               = 1'b1;
    in_valid          = 1'b0;
    in_a              = '0;
    in_b              = '0;
    operation_select  = 1'b0;
    invalid_operation = 1'b0;
    perform_operation = 1'b1;
    out_ready         = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst/out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst/result", result, 32'h0);
    check_eq("rst/flags", {30'b0, overflow, underflow}, 32'd0);
    check_eq("rst/in_ready_up", {31'b0, in_ready}, 32'd1);

    run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b1, 1'b0, 32'h40400000, 0, 0, 4, 0);
    run_op("sub_eq",    32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h00000000, 0, 0, 3, 0);
    run_op("neg_zero",  32'h80000000, 32'h00000000, 1'b0, 1'b0, 32'h80000000, 0, 0, 3, 0);
    run_op("norm23",    32'h3F800000, 32'h3F7FFFFF, 1'b0, 1'b0, 32'h33800000, 0, 0, 27, 0);
    run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b1, 1'b0, 32'h3F800000, 0, 0, 4, 0);
    run_op("tie_up",    32'h3F800000, 32'h33C00000, 1'b1, 1'b0, 32'h3F800001, 0, 0, 4, 0);
    run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0, 32'h7F800000, 1, 0, 4, 0);
    run_op("invalid",   32'h7F800000, 32'hFF800000, 1'b1, 1'b1, 32'h7FC00000, 0, 0, 1, 0);
    run_op("inf_b",     32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7F800000, 0, 0, 1, 0);
    run_op("underflow", 32'h00800001, 32'h00800000, 1'b0, 1'b0, 32'h00000000, 0, 1, 3, 0);
    run_op("norm1",     32'h40000000, 32'h3FC00000, 1'b0, 1'b0, 32'h3F000000, 0, 0, 5, 0);
    run_op("denorm",    32'h00000001, 32'h3F800000, 1'b1, 1'b0, 32'h3F800000, 0, 0, 4, 0);
    run_op("neg_res",   32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'hBF800000, 0, 0, 4, 0);
    run_op("hold",      32'h40000000, 32'h40000000, 1'b1, 1'b0, 32'h40800000, 0, 0, 4, 10);

    // Abort a long normalization with reset; nothing may come out afterwards.
    wait_ready("abort");
    drive(32'h3F800000, 32'h3F7FFFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort/busy", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort/ready_in_rst", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("abort/ready_after", {31'b0, in_ready}, 32'd1);
    check_eq("abort/result_clr", result, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("abort/no_stale", {31'b0, seen}, 32'd0);

    run_op("recover",   32'h3F800000, 32'h40000000, 1'b1, 1'b0, 32'h40400000, 0, 0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
